// File: rtl/simplerisc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : simplerisc_pkg                                                    |
// | Brief  : Shared SimpleRISC types: branch kinds, flag bits, ALU opcodes.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package simplerisc_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 4;
  localparam int RA_IDX = 15;

  localparam int FLAG_GT = 1;
  localparam int FLAG_EQ = 0;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_B    = 3'd1,
    BR_BEQ  = 3'd2,
    BR_BGT  = 3'd3,
    BR_CALL = 3'd4,
    BR_RET  = 3'd5
  } br_type_e;

  // ALU opcodes, decoded upstream by the ALU
  localparam logic [3:0] C_ALU_ADD = 4'd0;
  localparam logic [3:0] C_ALU_SUB = 4'd1;
  localparam logic [3:0] C_ALU_MUL = 4'd2;
  localparam logic [3:0] C_ALU_DIV = 4'd3;
  localparam logic [3:0] C_ALU_MOD = 4'd4;
  localparam logic [3:0] C_ALU_CMP = 4'd5;
  localparam logic [3:0] C_ALU_AND = 4'd6;
  localparam logic [3:0] C_ALU_OR  = 4'd7;
  localparam logic [3:0] C_ALU_NOT = 4'd8;
  localparam logic [3:0] C_ALU_MOV = 4'd9;
  localparam logic [3:0] C_ALU_LSL = 4'd10;
  localparam logic [3:0] C_ALU_LSR = 4'd11;
  localparam logic [3:0] C_ALU_ASR = 4'd12;

  localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == C_CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : branch_resolve                                                    |
// | Brief  : Combinational branch decision from branch kind and stored flags.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module branch_resolve #(
  parameter int XLEN = simplerisc_pkg::XLEN
) (
  input  logic [2:0]      br_type,
  input  logic [1:0]      flags,
  input  logic [XLEN-1:0] target,
  output logic            taken,
  output logic [XLEN-1:0] taken_pc
);
  import simplerisc_pkg::*;

  always_comb begin
    taken = 1'b0;
    case (br_type_e'(br_type))
      BR_B, BR_CALL, BR_RET: taken = 1'b1;
      BR_BEQ:                taken = flags[FLAG_EQ];
      BR_BGT:                taken = flags[FLAG_GT];
      default:               taken = 1'b0;
    endcase
  end

  assign taken_pc = target;

endmodule
`default_nettype wire

// File: rtl/ex_ma_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ex_ma_stage                                                       |
// | Brief  : EX->MA pipeline latch, flags register and branch redirect.        |
// |          Optional perf counters when EX_MA_PERF_CNT_EN is defined.         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module ex_ma_stage #(
  parameter int XLEN   = simplerisc_pkg::XLEN,
  parameter int REG_AW = simplerisc_pkg::REG_AW,
  parameter int RA_IDX = simplerisc_pkg::RA_IDX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [1:0]        in_alu_flags,
  input  logic              in_is_cmp,
  input  logic [2:0]        in_br_type,
  input  logic [XLEN-1:0]   in_br_target,
  input  logic [XLEN-1:0]   in_st_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_is_ld,
  input  logic              in_is_st,
  input  logic              in_is_wb,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_result,
  output logic [XLEN-1:0]   out_st_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_is_ld,
  output logic              out_is_st,
  output logic              out_is_wb,
  output logic [1:0]        flags_q,
  output logic              br_taken,
  output logic [XLEN-1:0]   br_pc
`ifdef EX_MA_PERF_CNT_EN
  ,
  output logic [31:0]       perf_br_taken,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flush
`endif
);
  import simplerisc_pkg::*;

  localparam logic [XLEN-1:0]   C_PC_STEP = XLEN'(4);
  localparam logic [REG_AW-1:0] C_RA      = REG_AW'(RA_IDX);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_result;
  logic [XLEN-1:0]   r_st_data;
  logic [REG_AW-1:0] r_rd;
  logic              r_is_ld;
  logic              r_is_st;
  logic              r_is_wb;
  logic [1:0]        r_flags;
  logic              r_br_taken;
  logic [XLEN-1:0]   r_br_pc;

  logic              w_accept;
  logic              w_is_call;
  logic              w_taken;
  logic [XLEN-1:0]   w_target;

  assign in_ready  = !flush && (!r_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_is_call = (in_br_type == BR_CALL);

  // Resolves against the flags held before this edge, so a cmp immediately
  // ahead of a conditional branch is already visible in r_flags.
  branch_resolve #(
    .XLEN (XLEN)
  ) u_branch_resolve (
    .br_type  (in_br_type),
    .flags    (r_flags),
    .target   (in_br_target),
    .taken    (w_taken),
    .taken_pc (w_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_result   <= '0;
      r_st_data  <= '0;
      r_rd       <= '0;
      r_is_ld    <= 1'b0;
      r_is_st    <= 1'b0;
      r_is_wb    <= 1'b0;
      r_flags    <= '0;
      r_br_taken <= 1'b0;
      r_br_pc    <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end

      if (w_accept) begin
        r_pc      <= in_pc;
        r_st_data <= in_st_data;
        r_is_ld   <= in_is_ld;
        r_is_st   <= in_is_st;
        // call links pc+4 into the return-address register
        r_result  <= w_is_call ? (in_pc + C_PC_STEP) : in_alu_result;
        r_rd      <= w_is_call ? C_RA : in_rd;
        r_is_wb   <= w_is_call ? 1'b1 : in_is_wb;
      end

      if (w_accept && in_is_cmp) begin
        r_flags <= in_alu_flags;
      end

      r_br_taken <= w_accept && w_taken;
      if (w_accept && w_taken) begin
        r_br_pc <= w_target;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_result  = r_result;
  assign out_st_data = r_st_data;
  assign out_rd      = r_rd;
  assign out_is_ld   = r_is_ld;
  assign out_is_st   = r_is_st;
  assign out_is_wb   = r_is_wb;
  assign flags_q     = r_flags;
  assign br_taken    = r_br_taken;
  assign br_pc       = r_br_pc;

`ifdef EX_MA_PERF_CNT_EN
  logic [31:0] r_perf_br;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_br    <= '0;
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (r_br_taken) begin
        r_perf_br <= sat_inc32(r_perf_br);
      end
      if (r_valid && !out_ready) begin
        r_perf_stall <= sat_inc32(r_perf_stall);
      end
      if (flush) begin
        r_perf_flush <= sat_inc32(r_perf_flush);
      end
    end
  end

  assign perf_br_taken = r_perf_br;
  assign perf_stall    = r_perf_stall;
  assign perf_flush    = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_ma_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ex_ma_stage                                                    |
// | Brief  : Directed scoreboard bench for ex_ma_stage.                        |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ex_ma_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_alu_result;
  logic [1:0]  in_alu_flags;
  logic        in_is_cmp;
  logic [2:0]  in_br_type;
  logic [31:0] in_br_target;
  logic [31:0] in_st_data;
  logic [3:0]  in_rd;
  logic        in_is_ld;
  logic        in_is_st;
  logic        in_is_wb;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_result;
  logic [31:0] out_st_data;
  logic [3:0]  out_rd;
  logic        out_is_ld;
  logic        out_is_st;
  logic        out_is_wb;
  logic [1:0]  flags_q;
  logic        br_taken;
  logic [31:0] br_pc;
`ifdef EX_MA_PERF_CNT_EN
  logic [31:0] perf_br_taken;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] sd;
    logic [3:0]  rd;
    logic        ld;
    logic        st;
    logic        wb;
  } exp_t;

  exp_t sb[$];

  ex_ma_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_alu_result (in_alu_result),
    .in_alu_flags  (in_alu_flags),
    .in_is_cmp     (in_is_cmp),
    .in_br_type    (in_br_type),
    .in_br_target  (in_br_target),
    .in_st_data    (in_st_data),
    .in_rd         (in_rd),
    .in_is_ld      (in_is_ld),
    .in_is_st      (in_is_st),
    .in_is_wb      (in_is_wb),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_result    (out_result),
    .out_st_data   (out_st_data),
    .out_rd        (out_rd),
    .out_is_ld     (out_is_ld),
    .out_is_st     (out_is_st),
    .out_is_wb     (out_is_wb),
    .flags_q       (flags_q),
    .br_taken      (br_taken),
    .br_pc         (br_pc)
`ifdef EX_MA_PERF_CNT_EN
    ,
    .perf_br_taken (perf_br_taken),
    .perf_stall    (perf_stall),
    .perf_flush    (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] res, input logic [1:0] fl,
                       input logic cmp, input logic [2:0] br, input logic [31:0] tgt,
                       input logic [31:0] sd, input logic [3:0] rd,
                       input logic ld, input logic st, input logic wb);
    in_valid      = 1'b1;
    in_pc         = pc;
    in_alu_result = res;
    in_alu_flags  = fl;
    in_is_cmp     = cmp;
    in_br_type    = br;
    in_br_target  = tgt;
    in_st_data    = sd;
    in_rd         = rd;
    in_is_ld      = ld;
    in_is_st      = st;
    in_is_wb      = wb;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] sd,
                      input logic [3:0] rd, input logic ld, input logic st, input logic wb);
    exp_t e;
    e.pc = pc; e.res = res; e.sd = sd; e.rd = rd; e.ld = ld; e.st = st; e.wb = wb;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 128'd1, 128'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 128'(out_valid), 128'd1);
      chk({tag, "_fields"},
          128'({out_pc, out_result, out_st_data, out_rd, out_is_ld, out_is_st, out_is_wb}),
          128'({e.pc, e.res, e.sd, e.rd, e.ld, e.st, e.wb}));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 128'(out_valid), 128'd0);
    chk("reset_flags_br", 128'({flags_q, br_taken, br_pc}), 128'd0);
    chk("reset_data", 128'({out_pc, out_result, out_st_data, out_rd, out_is_ld, out_is_st, out_is_wb}), 128'd0);
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // add r3 = 7
    drive(32'h10, 32'h7, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0, 4'd3, 1'b0, 1'b0, 1'b1);
    push(32'h10, 32'h7, 32'h0, 4'd3, 1'b0, 1'b0, 1'b1);
    step();
    check_out("add");
    chk("add_flags_br", 128'({flags_q, br_taken}), 128'd0);

    // cmp -> eq set, then beq back-to-back
    drive(32'h14, 32'h0, 2'b01, 1'b1, 3'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    push(32'h14, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("cmp");
    chk("cmp_flags", 128'(flags_q), 128'(2'b01));
    chk("cmp_br_taken", 128'(br_taken), 128'd0);

    drive(32'h18, 32'h0, 2'b10, 1'b0, 3'd2, 32'h100, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    push(32'h18, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("beq");
    chk("beq_taken", 128'({br_taken, br_pc}), 128'({1'b1, 32'h100}));
    chk("beq_flags_kept", 128'(flags_q), 128'(2'b01));

    drive(32'h1C, 32'h0, 2'b00, 1'b0, 3'd3, 32'h200, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    push(32'h1C, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("bgt");
    chk("bgt_not_taken", 128'({br_taken, br_pc}), 128'({1'b0, 32'h100}));

    // call wraps pc+4, links into r15
    drive(32'hFFFF_FFFC, 32'h1234, 2'b00, 1'b0, 3'd4, 32'h40, 32'h99, 4'd5, 1'b0, 1'b0, 1'b0);
    push(32'hFFFF_FFFC, 32'h0, 32'h99, 4'd15, 1'b0, 1'b0, 1'b1);
    step();
    check_out("call");
    chk("call_taken", 128'({br_taken, br_pc}), 128'({1'b1, 32'h40}));

    // store into latch, then back-pressure
    drive(32'h20, 32'hAA, 2'b00, 1'b0, 3'd0, 32'h0, 32'h55, 4'd1, 1'b0, 1'b1, 1'b0);
    push(32'h20, 32'hAA, 32'h55, 4'd1, 1'b0, 1'b1, 1'b0);
    step();
    check_out("st");
    chk("st_br_clear", 128'(br_taken), 128'd0);

    out_ready = 1'b0;
    drive(32'h24, 32'hBB, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0, 4'd2, 1'b1, 1'b0, 1'b1);
    #1;
    chk("stall_in_ready", 128'(in_ready), 128'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready_hold", 128'(in_ready), 128'd0);
      chk("stall_hold",
          128'({out_valid, out_pc, out_result, out_st_data, out_rd, out_is_ld, out_is_st, out_is_wb}),
          128'({1'b1, 32'h20, 32'hAA, 32'h55, 4'd1, 1'b0, 1'b1, 1'b0}));
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 128'(in_ready), 128'd1);
    push(32'h24, 32'hBB, 32'h0, 4'd2, 1'b1, 1'b0, 1'b1);
    step();
    check_out("ld_after_stall");

    // flush with a cmp and then a taken b
    flush = 1'b1;
    drive(32'h28, 32'h0, 2'b10, 1'b1, 3'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("flush_in_ready", 128'(in_ready), 128'd0);
    step();
    chk("flush_cmp", 128'({out_valid, flags_q, br_taken}), 128'({1'b0, 2'b01, 1'b0}));
    drive(32'h2C, 32'h0, 2'b00, 1'b0, 3'd1, 32'h300, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("flush_b", 128'({out_valid, br_taken, br_pc}), 128'({1'b0, 1'b0, 32'h40}));
    flush = 1'b0;

    drive(32'h30, 32'h55, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0, 4'd6, 1'b0, 1'b0, 1'b1);
    push(32'h30, 32'h55, 32'h0, 4'd6, 1'b0, 1'b0, 1'b1);
    step();
    check_out("add2");
    idle();
    step();
    chk("drain_valid", 128'(out_valid), 128'd0);

    drive(32'h34, 32'h0, 2'b11, 1'b1, 3'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    push(32'h34, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("cmp2");
    chk("cmp2_flags", 128'(flags_q), 128'(2'b11));
    idle();
`ifdef EX_MA_PERF_CNT_EN
    chk("perf_counts", 128'({perf_br_taken, perf_stall, perf_flush}),
        128'({32'd2, 32'd3, 32'd2}));
`endif

    // asynchronous reset mid-cycle
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid_flags", 128'({out_valid, flags_q}), 128'd0);
    chk("async_rst_data", 128'({out_pc, out_result, out_rd, out_is_wb, br_taken, br_pc}), 128'd0);
`ifdef EX_MA_PERF_CNT_EN
    chk("async_rst_perf", 128'({perf_br_taken, perf_stall, perf_flush}), 128'd0);
`endif
    chk("sb_drained", 128'(sb.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_ma_stage.md
Name: ex_ma_stage

Overview:
- Registered execute-to-memory boundary of the SimpleRISC pipeline; sits directly downstream of the combinational ALU.
- Captures the ALU result, store data and control into the MA latch.
- Owns the architectural flags register, which is written only by cmp.
- Resolves b/beq/bgt/call/ret and emits a one-cycle redirect pulse to fetch.
- Valid/ready handshake on both sides; flush input for squashing.

Parameters:
- XLEN, 32, datapath width (ALU result, PC, targets).
- REG_AW, 4, register-file address width.
- RA_IDX, 15, return-address register written by call.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  PC of instruction
- in_alu_result  in  XLEN  ALU result
- in_alu_flags  in  2  ALU flags: [1]=gt, [0]=eq
- in_is_cmp  in  1  instruction is cmp
- in_br_type  in  3  0 none, 1 b, 2 beq, 3 bgt, 4 call, 5 ret, 6-7 treated as none
- in_br_target  in  XLEN  branch/call target, or ra value for ret
- in_st_data  in  XLEN  store data (op2)
- in_rd  in  REG_AW  destination register
- in_is_ld, in_is_st, in_is_wb  in  1 each  load, store, writeback enables
- flush  in  1  squash latch and refuse input
- out_valid  out  1  MA latch holds a live instruction
- out_ready  in  1  memory stage consumes
- out_pc, out_result, out_st_data  out  XLEN  latched fields
- out_rd  out  REG_AW
- out_is_ld, out_is_st, out_is_wb  out  1 each
- flags_q  out  2  architectural flags
- br_taken  out  1  redirect pulse
- br_pc  out  XLEN  redirect target

Behaviour:
- Reset (async, rst_n=0):
  - out_valid, br_taken, flags_q, and all out_* data and control outputs = 0.
  - br_pc = 0.
- in_ready = !flush && (!out_valid || out_ready); purely combinational.
- Accept = in_valid && in_ready. On accept:
  - All in_* fields load into the out_* registers; out_valid=1 next cycle.
  - Latency is one cycle.
- No accept and out_ready=1: out_valid goes 0. No accept and out_ready=0: latch holds and all outputs are stable.
- flush=1:
  - out_valid=0 next cycle; no accept.
  - flags_q unchanged; br_taken=0 next cycle.
  - Flush wins over every simultaneous event.
- Flags:
  - On accept with in_is_cmp=1, flags_q <= in_alu_flags.
  - Otherwise flags_q holds; non-cmp ops never touch it.
- Branch resolution on accept, using flags_q as it was before this cycle's update:
  - taken if type 1, 4 or 5.
  - type 2 (beq): taken if flags_q[0]=1.
  - type 3 (bgt): taken if flags_q[1]=1.
  - A cmp is never a branch, so there is no same-instruction hazard.
  - cmp followed back-to-back by beq: the cmp updates flags_q on its accept edge, so the beq accepted next cycle sees the new value.
- br_taken is registered and high exactly one cycle after a taken accept; br_pc = in_br_target latched on the same edge. br_pc holds when no branch is taken.
- call: out_result <= in_pc + 4 (wraps mod 2^XLEN), out_rd <= RA_IDX, out_is_wb <= 1, overriding in_rd/in_alu_result.
- Redirect ownership: the stage does not squash itself on a taken branch; upstream asserts flush on younger stages.
- Reset asserted mid-transfer: in-flight instruction is lost and outputs return to reset values immediately.

Optional Feature:
- Macro EX_MA_PERF_CNT_EN.
- Defined: adds outputs perf_br_taken[31:0], perf_stall[31:0] and perf_flush[31:0].
  - perf_br_taken: counts br_taken cycles.
  - perf_stall: counts cycles with out_valid && !out_ready.
  - perf_flush: counts flush cycles.
  - All three reset to 0, saturate at 0xFFFFFFFF, and are not cleared by flush.
- Undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- Package simplerisc_pkg holds:
  - br_type_e enum (BR_NONE, BR_B, BR_BEQ, BR_BGT, BR_CALL, BR_RET).
  - Flag bit indices FLAG_GT=1, FLAG_EQ=0.
  - XLEN and RA_IDX constants.
  - ALU opcode constants (shared with the ALU).
- One sub-module: branch_resolve. Purely combinational: (br_type, flags_q, target) -> (taken, target).

Test Plan:
- Reset, then accept add with result 0x0000_0007, rd=3, wb=1 -> next cycle out_valid=1, out_result=0x7, out_rd=3, flags_q=00, br_taken=0.
- cmp with ALU flags=01, then back-to-back beq to 0x100 -> flags_q=01 after the cmp; br_taken pulses one cycle later with br_pc=0x100. Repeat with bgt -> not taken.
- call at pc=0xFFFF_FFFC, target 0x40 -> out_result=0x0000_0000 (wrap), out_rd=15, out_is_wb=1, br_taken=1, br_pc=0x40.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no second accept. Release -> next instruction accepted same cycle (in_ready=1).
- flush concurrent with in_valid=1 carrying a cmp (flags=10) -> out_valid=0, flags_q unchanged, br_taken=0.
- Assert rst_n=0 mid-cycle while out_valid=1 -> out_valid and flags_q clear immediately. With EX_MA_PERF_CNT_EN defined, all perf counters read 0.
